// File: rtl/lights_out_pkg.sv
// Shared types and constants for the lights-out puzzle: FSM states, 7-seg glyphs,
// LFSR taps and the neighbour toggle mask.
package lights_out_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, WON, LOST} state_t;

  // Galois form of x^16+x^14+x^13+x^11 for a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Active-low segments {g,f,e,d,c,b,a} for digits 0..9
  localparam logic [6:0] SEG7_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [15:0] toggle_mask(input logic [3:0] k, input logic [4:0] n);
    logic [15:0] m;
    m = '0;
    m[k] = 1'b1;
    if (k != 4'd0) m[k - 4'd1] = 1'b1;
    if (({1'b0, k} + 5'd1) < n) m[k + 4'd1] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/lights_out_game_if.sv
// Player-side bundle of the lights-out game: switch/start inputs and display outputs.
interface lights_out_game_if #(parameter int N_LIGHTS = 8);
  logic                start;
  logic [N_LIGHTS-1:0] switch;
  logic [N_LIGHTS-1:0] light;
  logic                finish;
  logic [6:0]          tries;
  logic [6:0]          out10;
  logic [6:0]          out1;
  logic                timeout;
  logic [7:0]          time_left;

  modport master (output start, switch,
                  input  light, finish, tries, out10, out1, timeout, time_left);
  modport slave  (input  start, switch,
                  output light, finish, tries, out10, out1, timeout, time_left);
endinterface

// File: rtl/lights_out_game_seg7_decimal.sv
// Splits a 0..99 count into tens and ones and maps each to an active-low 7-seg glyph.
module seg7_decimal
  import lights_out_pkg::*;
(
  input  logic [6:0] tries,
  output logic [6:0] out10,
  output logic [6:0] out1
);
  logic [3:0] tens;
  logic [3:0] ones;

  always_comb begin
    tens  = 4'(tries / 7'd10);
    ones  = 4'(tries % 7'd10);
    out10 = SEG7_DIGIT[tens];
    out1  = SEG7_DIGIT[ones];
  end
endmodule

// File: rtl/lights_out_game.sv
// Lights-out puzzle: FSM, start-pattern LFSR, switch edge detect and press counter.
// Define LIGHTS_COUNTDOWN_EN to add the per-game countdown and the LOST outcome.
module lights_out_game
  import lights_out_pkg::*;
#(
  parameter int          N_LIGHTS      = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          TICKS_PER_SEC = 50000000,
  parameter int          COUNTDOWN_SEC = 10
) (
  input logic               clk,
  input logic               reset,
  lights_out_game_if.slave  bus
);
  state_t              state, state_next;
  logic [15:0]         lfsr, lfsr_next;
  logic [N_LIGHTS-1:0] switch_q, press_edge;
  logic [N_LIGHTS-1:0] light, light_next;
  logic [6:0]          tries, tries_next;
  logic [6:0]          out10_next, out1_next, out10_r, out1_r;
  logic                finish_r;
  logic [3:0]          start_k, press_j;

  assign press_edge = bus.switch & ~switch_q;
  assign start_k    = 4'(lfsr % 16'(N_LIGHTS));

  // Digits are decoded from the next count so they change on the same edge as tries
  seg7_decimal u_seg7 (.tries(tries_next), .out10(out10_next), .out1(out1_next));

`ifdef LIGHTS_COUNTDOWN_EN
  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  logic [TICK_W-1:0] tick, tick_next;
  logic [7:0]        time_left, time_next;
  logic              timeout_r;
`endif

  always_comb begin
    lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    state_next = state;
    light_next = light;
    tries_next = tries;
    press_j    = '0;
    for (int i = N_LIGHTS - 1; i >= 0; i--) begin
      if (press_edge[i]) press_j = 4'(i);
    end
`ifdef LIGHTS_COUNTDOWN_EN
    tick_next = tick;
    time_next = time_left;
`endif
    if (bus.start) begin
      state_next = PLAY;
      light_next = N_LIGHTS'(toggle_mask(start_k, 5'(N_LIGHTS)));
      tries_next = '0;
`ifdef LIGHTS_COUNTDOWN_EN
      tick_next = '0;
      time_next = 8'(COUNTDOWN_SEC);
`endif
    end else if (state == PLAY) begin
      if (press_edge != '0) begin
        light_next = light ^ N_LIGHTS'(toggle_mask(press_j, 5'(N_LIGHTS)));
        tries_next = (tries >= 7'd99) ? 7'd99 : tries + 7'd1;
      end
`ifdef LIGHTS_COUNTDOWN_EN
      if (tick == TICK_W'(TICKS_PER_SEC - 1)) begin
        tick_next = '0;
        if (time_left != 8'd0) time_next = time_left - 8'd1;
        if (time_left == 8'd1) state_next = LOST;
      end else begin
        tick_next = tick + 1'b1;
      end
`endif
      // A winning press outranks a countdown expiring on the same edge
      if (light_next == '0) state_next = WON;
    end
  end

  always_ff @(posedge clk) begin
    switch_q <= bus.switch;
    if (reset) begin
      state    <= IDLE;
      lfsr     <= LFSR_SEED;
      light    <= '0;
      tries    <= '0;
      finish_r <= 1'b0;
      out10_r  <= SEG7_DIGIT[0];
      out1_r   <= SEG7_DIGIT[0];
`ifdef LIGHTS_COUNTDOWN_EN
      tick      <= '0;
      time_left <= '0;
      timeout_r <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      lfsr     <= lfsr_next;
      light    <= light_next;
      tries    <= tries_next;
      finish_r <= (state_next == WON);
      out10_r  <= out10_next;
      out1_r   <= out1_next;
`ifdef LIGHTS_COUNTDOWN_EN
      tick      <= tick_next;
      time_left <= time_next;
      timeout_r <= (state_next == LOST);
`endif
    end
  end

  assign bus.light  = light;
  assign bus.tries  = tries;
  assign bus.finish = finish_r;
  assign bus.out10  = out10_r;
  assign bus.out1   = out1_r;
`ifdef LIGHTS_COUNTDOWN_EN
  assign bus.timeout   = timeout_r;
  assign bus.time_left = time_left;
`else
  assign bus.timeout   = 1'b0;
  assign bus.time_left = 8'd0;
`endif
endmodule

// File: tb/tb_lights_out_game.sv
// Directed bench for lights_out_game: vector table for the opening games plus
// hand-written sequences for saturation, countdown and mid-game reset.
module tb_lights_out_game;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  lights_out_game_if #(.N_LIGHTS(8)) bus ();

  lights_out_game #(
    .N_LIGHTS(8), .LFSR_SEED(16'hACE1), .TICKS_PER_SEC(4), .COUNTDOWN_SEC(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [7:0] sw;
    logic [7:0] light;
    logic [6:0] tries;
    logic       finish;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; default: return 7'h10;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] light, input int tries,
                             input logic finish);
    check({tag, " light"},  32'(bus.light),  32'(light));
    check({tag, " tries"},  32'(bus.tries),  32'(tries));
    check({tag, " finish"}, 32'(bus.finish), 32'(finish));
    check({tag, " out10"},  32'(bus.out10),  32'(seg(tries / 10)));
    check({tag, " out1"},   32'(bus.out1),   32'(seg(tries % 10)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // LFSR values seen at each vector edge: ACE1, E270, 7138, 389C, 1C4E (k=6)
    vecs[0]  = '{1'b1, 8'h00, 8'h07, 7'd0, 1'b0};
    vecs[1]  = '{1'b0, 8'h02, 8'h00, 7'd1, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 7'd1, 1'b1};
    vecs[3]  = '{1'b0, 8'h04, 8'h00, 7'd1, 1'b1};
    vecs[4]  = '{1'b1, 8'h04, 8'hE0, 7'd0, 1'b0};
    vecs[5]  = '{1'b0, 8'h25, 8'hE3, 7'd1, 1'b0};
    vecs[6]  = '{1'b0, 8'hA5, 8'h23, 7'd2, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 8'h23, 7'd2, 1'b0};
    vecs[8]  = '{1'b0, 8'h08, 8'h3F, 7'd3, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 8'h3F, 7'd3, 1'b0};
    vecs[10] = '{1'b0, 8'h02, 8'h38, 7'd4, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 8'h38, 7'd4, 1'b0};
    vecs[12] = '{1'b0, 8'h10, 8'h00, 7'd5, 1'b1};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.switch = 8'h00;
    step();
    step();
    check_state("reset", 8'h00, 0, 1'b0);
    check("reset timeout", 32'(bus.timeout), 32'd0);
    check("reset time_left", 32'(bus.time_left), 32'd0);

    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bus.start  = vecs[i].start;
      bus.switch = vecs[i].sw;
      step();
      check_state($sformatf("vec%0d", i), vecs[i].light, int'(vecs[i].tries), vecs[i].finish);
    end
    bus.start = 1'b0;
    bus.switch = 8'h00;

`ifndef LIGHTS_COUNTDOWN_EN
    // Saturation: switch[0] toggles 07 <-> 04, never winning
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int p = 0; p < 120; p++) begin
      bus.switch = 8'h01;
      step();
      bus.switch = 8'h00;
      step();
    end
    check_state("sat", 8'h07, 99, 1'b0);
    check("sat out10 raw", 32'(bus.out10), 32'h10);
`endif

`ifdef LIGHTS_COUNTDOWN_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("cd load", 32'(bus.time_left), 32'd3);
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("cd time c%0d", c), 32'(bus.time_left), 32'(c < 4 ? 3 : c < 8 ? 2 : c < 12 ? 1 : 0));
      check($sformatf("cd timeout c%0d", c), 32'(bus.timeout), 32'(c >= 12));
    end
    bus.switch = 8'h02;
    step();
    bus.switch = 8'h00;
    check_state("lost press", 8'h07, 0, 1'b0);
    check("lost timeout", 32'(bus.timeout), 32'd1);
`endif

    // Mid-game reset with switch[2] held and start asserted
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.switch = 8'h04;
    step();
    check_state("pre-reset", 8'h09, 1, 1'b0);
    reset = 1'b1;
    bus.start = 1'b1;
    step();
    check_state("mid reset", 8'h00, 0, 1'b0);
    check("mid reset timeout", 32'(bus.timeout), 32'd0);
    check("mid reset time_left", 32'(bus.time_left), 32'd0);
    reset = 1'b0;
    bus.switch = 8'h0C;
    step();
    check_state("start+edge", 8'h07, 0, 1'b0);
    bus.start = 1'b0;
    step();
    check_state("post start", 8'h07, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
